// File: rtl/timeout_display.sv
// Display side of the stopwatch timeout path: captures the elapsed count on a
// sign_enable rising edge, converts it to BCD serially, then scans it onto a
// multiplexed active-low 7-segment display with leading-zero blanking.
module timeout_display #(
    parameter int COUNT_WIDTH = 32,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sign_enable,
    input  logic [COUNT_WIDTH-1:0] sign_timeout,
    output logic [6:0]             seg,
    output logic [NUM_DIGITS-1:0]  an,
    output logic                   busy,
    output logic                   overflow
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (COUNT_WIDTH > 1) ? $clog2(COUNT_WIDTH) : 1;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [COUNT_WIDTH-1:0] MAX_VAL    = COUNT_WIDTH'(10 ** NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]       LAST_SHIFT = CNT_W'(COUNT_WIDTH - 1);
    localparam logic [PRE_W-1:0]       LAST_PRE   = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        BLANK   = 2'd0,
        CONVERT = 2'd1,
        SHOW    = 2'd2
    } state_t;

    state_t                 state;
    logic                   en_d;
    logic [COUNT_WIDTH-1:0] bin;
    logic [BCD_W-1:0]       bcd;
    logic [BCD_W-1:0]       digits;
    logic [CNT_W-1:0]       shift_cnt;
    logic [PRE_W-1:0]       prescaler;
    logic [IDX_W-1:0]       scan_idx;

    logic                   capture;
    logic                   over;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W-1:0]       bcd_shift;
    logic [COUNT_WIDTH-1:0] bin_shift;
    logic [NUM_DIGITS-1:0]  shown;
    logic                   nz;
    logic [3:0]             cur_digit;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            return nib + 4'd3;
        end else begin
            return nib;
        end
    endfunction

    // gfedcba, active-low
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    assign capture   = sign_enable & ~en_d;
    assign over      = (sign_timeout > MAX_VAL);
    assign cur_digit = digits[{scan_idx, 2'b00} +: 4];

    // One double-dabble step: add 3 to every nibble >= 5, then shift the pair left.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = add3(bcd[4*i +: 4]);
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], bin[COUNT_WIDTH-1]};
        bin_shift = {bin[COUNT_WIDTH-2:0], 1'b0};
    end

    // A digit is lit if it or any more significant digit is nonzero; digit 0 always lit.
    always_comb begin
        shown = '0;
        nz    = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz       = nz | (digits[4*i +: 4] != 4'd0);
            shown[i] = nz | (i == 0);
        end
    end

    // Control FSM, conversion datapath, scan timing and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BLANK;
            en_d      <= 1'b0;
            bin       <= '0;
            bcd       <= '0;
            digits    <= '0;
            shift_cnt <= '0;
            prescaler <= '0;
            scan_idx  <= '0;
            seg       <= 7'h7F;
            an        <= '1;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            en_d <= sign_enable;

            if (prescaler == LAST_PRE) begin
                prescaler <= '0;
                scan_idx  <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
            end else begin
                prescaler <= prescaler + PRE_W'(1);
            end

            case (state)
                BLANK: begin
                    seg  <= 7'h7F;
                    an   <= '1;
                    busy <= 1'b0;
                    if (capture) begin
                        state     <= CONVERT;
                        busy      <= 1'b1;
                        shift_cnt <= '0;
                        bcd       <= '0;
                        bin       <= over ? MAX_VAL : sign_timeout;
                        overflow  <= over;
                    end
                end
                CONVERT: begin
                    seg <= 7'h7F;
                    an  <= '1;
                    if (!sign_enable) begin
                        state <= BLANK;
                        busy  <= 1'b0;
                    end else begin
                        bin <= bin_shift;
                        bcd <= bcd_shift;
                        if (shift_cnt == LAST_SHIFT) begin
                            digits <= bcd_shift;
                            state  <= SHOW;
                            busy   <= 1'b0;
                        end else begin
                            shift_cnt <= shift_cnt + CNT_W'(1);
                        end
                    end
                end
                SHOW: begin
                    an  <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << scan_idx);
                    seg <= shown[scan_idx] ? seg_code(cur_digit) : 7'h7F;
                    if (!sign_enable) begin
                        state <= BLANK;
                    end else if (capture) begin
                        state     <= CONVERT;
                        busy      <= 1'b1;
                        shift_cnt <= '0;
                        bcd       <= '0;
                        bin       <= over ? MAX_VAL : sign_timeout;
                        overflow  <= over;
                    end else begin
                        state <= SHOW;
                    end
                end
                default: begin
                    state <= BLANK;
                    seg   <= 7'h7F;
                    an    <= '1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
